// File: rtl/mux8way_rr_stream.sv
// Eight-to-one round-robin streaming multiplexer with a one-entry output register.
// Each beat leaving the register is tagged with the index of the port it came from.
module mux8way_rr_stream #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [7:0]         in_valid,
    output logic [7:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr_q, ptr_d;

    logic       grant_found;
    logic [2:0] grant_idx;
    logic       can_load;
    logic       transfer;

    assign can_load = (state_q == ST_EMPTY) || out_ready;

    // The scan starts at ptr_q, so the first valid port found has the highest priority.
    always_comb begin : arbiter
        logic [2:0] cand;
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        cand        = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign transfer = reset_n && grant_found && can_load;

    always_comb begin
        in_ready = 8'h00;
        if (transfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (transfer) begin
            state_d = ST_FULL;
            data_d  = in_data[grant_idx*WIDTH +: WIDTH];
            sel_d   = grant_idx;
            ptr_d   = grant_idx + 3'd1;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux8way_rr_stream.sv
// Directed bench for mux8way_rr_stream: a table of per-cycle vectors plus
// hand-written reset sequences.
module tb_mux8way_rr_stream;

    localparam int WIDTH = 16;

    logic               clock;
    logic               reset_n;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    logic [WIDTH-1:0] port_data [8];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  valid;
        logic        oready;
        logic [15:0] p5;
        logic [7:0]  exp_ready;
        logic        exp_ov;
        logic [15:0] exp_data;
        logic [2:0]  exp_sel;
    } vec_t;

    vec_t vq[$];

    mux8way_rr_stream #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < 8; i++) begin
            in_data[i*WIDTH +: WIDTH] = port_data[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] v, input logic r, input logic [15:0] p5,
                       input logic [7:0] er, input logic eov, input logic [15:0] ed,
                       input logic [2:0] es);
        vec_t t;
        t.valid = v; t.oready = r; t.p5 = p5;
        t.exp_ready = er; t.exp_ov = eov; t.exp_data = ed; t.exp_sel = es;
        vq.push_back(t);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) port_data[i] = 16'h00A0 + 16'(i);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        reset_n   = 1'b0;

        // Full sweep: one beat per cycle, ports 0..7 then wrap to 0.
        for (int i = 0; i < 8; i++)
            add(8'hFF, 1'b1, 16'h00A5, 8'(1 << i), 1'b1, 16'h00A0 + 16'(i), 3'(i));
        add(8'hFF, 1'b1, 16'h00A5, 8'h01, 1'b1, 16'h00A0, 3'd0);
        // Port 5 alone, then drain, then ptr=6 picks port 7 over port 5.
        add(8'h20, 1'b1, 16'h1234, 8'h20, 1'b1, 16'h1234, 3'd5);
        add(8'h00, 1'b1, 16'h1234, 8'h00, 1'b0, 16'h0000, 3'd0);
        add(8'hA0, 1'b1, 16'h1234, 8'h80, 1'b1, 16'h00A7, 3'd7);
        // Four-cycle stall with ports 2 and 6 waiting, then drain+load on one edge.
        for (int i = 0; i < 4; i++)
            add(8'h44, 1'b0, 16'h1234, 8'h00, 1'b1, 16'h00A7, 3'd7);
        add(8'h44, 1'b1, 16'h1234, 8'h04, 1'b1, 16'h00A2, 3'd2);
        add(8'h40, 1'b1, 16'h1234, 8'h40, 1'b1, 16'h00A6, 3'd6);
        // ptr=7 with ports 0 and 7 valid: 7 first, then wrap to 0.
        add(8'h81, 1'b1, 16'h1234, 8'h80, 1'b1, 16'h00A7, 3'd7);
        add(8'h01, 1'b1, 16'h1234, 8'h01, 1'b1, 16'h00A0, 3'd0);
        add(8'h00, 1'b1, 16'h1234, 8'h00, 1'b0, 16'h0000, 3'd0);

        // Reset with all ports valid.
        repeat (2) @(negedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h00);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vq[n]) begin
            if (n != 0) @(negedge clock);
            in_valid     = vq[n].valid;
            out_ready    = vq[n].oready;
            port_data[5] = vq[n].p5;
            #1;
            check($sformatf("v%0d_in_ready", n), 32'(in_ready), 32'(vq[n].exp_ready));
            @(posedge clock);
            #1;
            check($sformatf("v%0d_out_valid", n), 32'(out_valid), 32'(vq[n].exp_ov));
            if (vq[n].exp_ov) begin
                check($sformatf("v%0d_out_data", n), 32'(out_data), 32'(vq[n].exp_data));
                check($sformatf("v%0d_out_sel", n), 32'(out_sel), 32'(vq[n].exp_sel));
            end
        end

        // Mid-operation reset: load port 3 (ptr=1), then pulse reset while full.
        @(negedge clock);
        in_valid  = 8'h08;
        out_ready = 1'b0;
        #1;
        check("pre_rst_in_ready", 32'(in_ready), 32'h08);
        @(posedge clock);
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'h1);
        check("pre_rst_out_sel", 32'(out_sel), 32'h3);
        in_valid = 8'hFF;
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_in_ready", 32'(in_ready), 32'h00);
        check("async_rst_out_data", 32'(out_data), 32'h0);
        @(negedge clock);
        in_valid  = 8'h00;
        out_ready = 1'b1;
        reset_n   = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
            check("held_beat_gone", 32'(out_valid), 32'h0);
        end
        // ptr must be back at 0: ports 3 and 7 valid selects 3 (a stale ptr=4 would pick 7).
        @(negedge clock);
        in_valid = 8'h88;
        #1;
        check("ptr_reset_in_ready", 32'(in_ready), 32'h08);
        @(posedge clock);
        #1;
        check("ptr_reset_out_valid", 32'(out_valid), 32'h1);
        check("ptr_reset_out_sel", 32'(out_sel), 32'h3);
        check("ptr_reset_out_data", 32'(out_data), 32'h00A3);

        @(negedge clock);
        in_valid = 8'h00;
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
